mdu_hilo: RTL
=============

# mdu_hilo

Parametrised multiply/divide unit with HI/LO result registers for the pipelined MIPS core. It sits beside the execute-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage. It runs multiplies over a configurable latency and divides as an iterative restoring divider. It exposes `busy` so the hazard unit can stall MFHI/MFLO and back-to-back mul/div ops in decode.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MUL_LAT`, 4: multiply latency in cycles, ≥1.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `startE` in 1: op valid in execute; sampled only when `busy`=0.
- `opE` in 3: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
- `srcaE` in WIDTH: rs operand (dividend / multiplicand / MTxx data).
- `srcbE` in WIDTH: rt operand (divisor / multiplier).
- `busy` out 1: mul/div in flight; HI/LO not valid.
- `done` out 1: one-cycle pulse on the cycle after HI/LO are written by a mul/div.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

Clock and reset: one clock, `clk`; `reset` is asynchronous and active-high.

## Operation
- States: IDLE, MUL, DIV, FIX.
  - IDLE + `startE` + MULT/MULTU → MUL, counter = MUL_LAT-1.
  - IDLE + `startE` + DIV/DIVU → DIV, counter = WIDTH-1.
  - MUL at counter 0 → IDLE.
  - DIV at counter 0 → FIX.
  - FIX → IDLE.
- MTHI/MTLO in IDLE: write `hi`/`lo` from `srcaE` at the next edge. No state change, `busy` stays 0, no `done`.
- Multiply:
  - Operands are captured at accept.
  - The 2·WIDTH product is signed (MULT) or unsigned (MULTU).
  - {hi,lo} = product, written on the MUL→IDLE edge.
  - The internal multiplier may be pipelined freely within MUL_LAT.
- Divide:
  - At accept, capture |a|, |b| for DIV, raw values for DIVU, and the sign flags.
  - Restoring division runs one quotient bit per cycle, MSB first.
  - FIX applies signs: quotient negated if the operand signs differ; remainder takes the dividend's sign (truncation toward zero).
  - lo = quotient, hi = remainder, written on the FIX→IDLE edge.
- Divide by zero:
  - DIVU: lo = all ones, hi = dividend.
  - DIV: lo = all ones if dividend ≥ 0 else 1, hi = dividend.
  - The full WIDTH+1 latency is still taken.
- Signed overflow (DIV of −2^(WIDTH−1) by −1): lo = −2^(WIDTH−1), hi = 0.
- `startE` while `busy`=1 is ignored (no queueing); the hazard unit guarantees this does not occur. Reserved opcode is ignored.
- HI/LO keep their old values throughout an operation until the final write edge.

## Timing
- Reset (async): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0, operand regs 0.
- Op accepted at edge N (IDLE, `startE`=1):
  - `busy`=1 from after edge N.
  - MUL: `busy` high for MUL_LAT cycles; hi/lo update and `busy` falls at edge N+MUL_LAT.
  - DIV: `busy` high for WIDTH+1 cycles; hi/lo update at edge N+WIDTH+1.
  - `done`=1 for exactly the cycle following that edge.
- A new op may be accepted on the same edge `busy` falls only if `startE` is sampled with `busy`=0, i.e. the earliest back-to-back accept is edge N+lat+1... no gap cycle beyond the IDLE cycle.
- MTHI/MTLO accepted at edge N: the register is visible after edge N (0-cycle busy).
- Reset asserted mid-operation: abort immediately, return to the reset values, no `done`.

## Test plan
- Reset mid-DIV: assert `reset` at cycle 10 of a DIV → `busy`=0, `hi`=`lo`=0 asynchronously; no `done` pulse follows.
- MULTU, WIDTH=32, MUL_LAT=4: a=0xFFFFFFFF, b=0xFFFFFFFF → after 4 busy cycles hi=0xFFFFFFFE, lo=0x00000001, `done` one cycle. MULT on the same operands → hi=0, lo=1.
- DIV: a=−7 (0xFFFFFFF9), b=2 → after 33 busy cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=7, b=2 → lo=3, hi=1.
- Edge divides:
  - DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
  - DIV −5/0 → lo=1, hi=0xFFFFFFFB.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles → hi=0x1234, lo=0x5678, `busy` never asserts. `startE` with MULT asserted mid-DIV → ignored; only the DIV result is written.

Source files
------------

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO result registers for the execute stage.
// Multiplies complete after MUL_LAT cycles; divides use a restoring divider plus a sign-fix cycle.
module mdu_hilo #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PW      = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] opa, opb, rem;
  logic            mul_signed, neg_q, neg_r;

  logic accept_mul, accept_div, wr_hi, wr_lo, mul_fin, div_fin;

  // Next-state and control strobes
  always_comb begin
    state_d    = state;
    accept_mul = 1'b0;
    accept_div = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    mul_fin    = 1'b0;
    div_fin    = 1'b0;
    case (state)
      IDLE: if (startE) begin
        case (opE)
          OP_MULT, OP_MULTU: begin state_d = MUL; accept_mul = 1'b1; end
          OP_DIV, OP_DIVU:   begin state_d = DIV; accept_div = 1'b1; end
          OP_MTHI:           wr_hi = 1'b1;
          OP_MTLO:           wr_lo = 1'b1;
          default:           ;
        endcase
      end
      MUL: if (cnt == '0) begin state_d = IDLE; mul_fin = 1'b1; end
      DIV: if (cnt == '0) state_d = FIX;
      FIX: begin state_d = IDLE; div_fin = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      done  <= mul_fin | div_fin;
    end
  end

  // Operand conditioning at accept: magnitudes and result signs for signed divide
  logic             div_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign div_signed = (opE == OP_DIV);
  assign a_neg      = div_signed & srcaE[WIDTH-1];
  assign b_neg      = div_signed & srcbE[WIDTH-1];
  assign abs_a      = a_neg ? -srcaE : srcaE;
  assign abs_b      = b_neg ? -srcbE : srcbE;

  // Product from captured operands, sign- or zero-extended to the full width
  logic [PW-1:0] ext_a, ext_b, prod;
  assign ext_a = mul_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
  assign ext_b = mul_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
  assign prod  = ext_a * ext_b;

  // One restoring step: opa shifts the dividend out and the quotient in
  logic [WIDTH:0]   rem_shift;
  logic             ge;
  logic [WIDTH-1:0] rem_next, q_next, q_fix, r_fix;
  assign rem_shift = {rem, opa[WIDTH-1]};
  assign ge        = (rem_shift >= {1'b0, opb});
  assign rem_next  = ge ? WIDTH'(rem_shift - {1'b0, opb}) : rem_shift[WIDTH-1:0];
  assign q_next    = {opa[WIDTH-2:0], ge};
  assign q_fix     = neg_q ? -opa : opa;
  assign r_fix     = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      opa        <= '0;
      opb        <= '0;
      rem        <= '0;
      mul_signed <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      if (accept_mul) begin
        opa        <= srcaE;
        opb        <= srcbE;
        mul_signed <= (opE == OP_MULT);
        cnt        <= CW'(MUL_LAT - 1);
      end else if (accept_div) begin
        opa   <= abs_a;
        opb   <= abs_b;
        rem   <= '0;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt   <= CW'(WIDTH - 1);
      end else if (state == DIV) begin
        opa <= q_next;
        rem <= rem_next;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (state == MUL && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (mul_fin) begin
        hi <= prod[PW-1:WIDTH];
        lo <= prod[WIDTH-1:0];
      end else if (div_fin) begin
        hi <= r_fix;
        lo <= q_fix;
      end else begin
        if (wr_hi) hi <= srcaE;
        if (wr_lo) lo <= srcaE;
      end
    end
  end

endmodule
